ipv4_header_extractor: RTL and testbench

- Front-end parser directly upstream of the Bloom filter lookup stage.
- Accepts Ethernet frames as a 32-bit ready/valid word stream and extracts the IPv4 source and destination addresses.
- Assigns each IPv4 frame a sequential 16-bit tag and presents {src_ip, dest_ip, tag} to the filter with a single-cycle enable pulse, honouring the filter's busy flag.
- Drops non-IPv4 and runt frames without emitting anything.

---
 rtl/ipv4_header_extractor_if.sv | 30 +++
 rtl/ipv4_header_extractor.sv | 160 ++++++++++++++++
 tb/tb_ipv4_header_extractor.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ipv4_header_extractor_if.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_header_extractor_if
// Purpose  : Frame stream in, Bloom-filter key out, for ipv4_header_extractor.
// Revision : 1.0  initial release
// ============================================================================
interface ipv4_header_extractor_if #(
  parameter int unsigned TAG_WIDTH = 16
);
  logic [31:0]          s_tdata;
  logic                 s_tvalid;
  logic                 s_tlast;
  logic                 s_tready;
  logic                 busy;
  logic                 enable;
  logic [31:0]          src_ip;
  logic [31:0]          dest_ip;
  logic [TAG_WIDTH-1:0] tag;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, busy,
    output s_tready, enable, src_ip, dest_ip, tag
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, busy,
    input  s_tready, enable, src_ip, dest_ip, tag
  );
endinterface
`default_nettype wire

// File: rtl/ipv4_header_extractor.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_header_extractor
// Purpose  : Parses Ethernet/IPv4 word stream, emits {src, dst, tag} to filter.
//            Optional forwarded/dropped frame counters: IPV4_EXTRACT_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module ipv4_header_extractor #(
  parameter int unsigned TAG_WIDTH      = 16,
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ipv4_header_extractor_if.slave   bus
`ifdef IPV4_EXTRACT_STATS_EN
  ,
  output logic [15:0]              frames_fwd,
  output logic [15:0]              frames_drop
`endif
);

  localparam logic [1:0] c_st_parse = 2'd0;
  localparam logic [1:0] c_st_emit  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  logic [1:0]           state_q,   state_d;
  logic [3:0]           wcnt_q,    wcnt_d;
  logic                 last_q,    last_d;
  logic                 rdy_q,     rdy_d;
  logic [TAG_WIDTH-1:0] tag_cnt_q, tag_cnt_d;
  logic [TAG_WIDTH-1:0] tag_q,     tag_d;
  logic [31:0]          src_q,     src_d;
  logic [31:0]          dst_q,     dst_d;

  logic                 w_ready;
  logic                 w_beat;
  logic                 w_emit;
  logic                 w_drop;
  logic                 w_bad_hdr;

`ifdef IPV4_EXTRACT_STATS_EN
  logic [15:0]          fwd_q,  fwd_d;
  logic [15:0]          drop_q, drop_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_st_parse;
      wcnt_q    <= 4'd0;
      last_q    <= 1'b0;
      rdy_q     <= 1'b0;
      tag_cnt_q <= '0;
      tag_q     <= '0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
`ifdef IPV4_EXTRACT_STATS_EN
      fwd_q     <= 16'd0;
      drop_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      last_q    <= last_d;
      rdy_q     <= rdy_d;
      tag_cnt_q <= tag_cnt_d;
      tag_q     <= tag_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
`ifdef IPV4_EXTRACT_STATS_EN
      fwd_q     <= fwd_d;
      drop_q    <= drop_d;
`endif
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    last_d    = last_q;
    rdy_d     = 1'b1;
    tag_cnt_d = tag_cnt_q;
    tag_d     = tag_q;
    src_d     = src_q;
    dst_d     = dst_q;
    w_drop    = 1'b0;
    w_bad_hdr = (bus.s_tdata[31:16] != ETHERTYPE_IPV4) || (bus.s_tdata[15:12] != 4'd4);

    if (w_beat) begin
      if (bus.s_tlast)
        wcnt_d = 4'd0;
      else if (wcnt_q != 4'd15)
        wcnt_d = wcnt_q + 4'd1;
    end

    case (state_q)
      c_st_parse: begin
        if (w_beat) begin
          case (wcnt_q)
            4'd6: src_d[31:16] = bus.s_tdata[15:0];
            4'd7: begin
              src_d[15:0]  = bus.s_tdata[31:16];
              dst_d[31:16] = bus.s_tdata[15:0];
            end
            4'd8: dst_d[15:0] = bus.s_tdata[31:16];
            default: ;
          endcase

          // A bad header that is also the last beat counts as one drop only
          if (wcnt_q == 4'd3 && w_bad_hdr) begin
            w_drop = 1'b1;
            if (!bus.s_tlast)
              state_d = c_st_drain;
          end else if (bus.s_tlast && wcnt_q < 4'd8) begin
            w_drop = 1'b1;
          end else if (wcnt_q == 4'd8) begin
            state_d = c_st_emit;
            last_d  = bus.s_tlast;
          end
        end
      end
      c_st_emit: begin
        if (w_emit) begin
          tag_d     = tag_cnt_q;
          tag_cnt_d = tag_cnt_q + 1'b1;
          state_d   = last_q ? c_st_parse : c_st_drain;
        end
      end
      c_st_drain: begin
        if (w_beat && bus.s_tlast)
          state_d = c_st_parse;
      end
      default: state_d = c_st_parse;
    endcase

`ifdef IPV4_EXTRACT_STATS_EN
    fwd_d  = (w_emit && fwd_q != 16'hFFFF)  ? fwd_q + 16'd1  : fwd_q;
    drop_d = (w_drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
`endif
  end

  // Outputs; the tag bypasses its holding register during the pulse itself
  always_comb begin
    w_ready      = rdy_q && (state_q != c_st_emit);
    w_emit       = (state_q == c_st_emit) && !bus.busy;
    w_beat       = bus.s_tvalid && w_ready;
    bus.s_tready = w_ready;
    bus.enable   = w_emit;
    bus.src_ip   = src_q;
    bus.dest_ip  = dst_q;
    bus.tag      = w_emit ? tag_cnt_q : tag_q;
`ifdef IPV4_EXTRACT_STATS_EN
    frames_fwd   = fwd_q;
    frames_drop  = drop_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_ipv4_header_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipv4_header_extractor
// Purpose  : Directed + randomized frames against a byte-level frame model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ipv4_header_extractor;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipv4_header_extractor_if #(.TAG_WIDTH(16)) bus ();

`ifdef IPV4_EXTRACT_STATS_EN
  logic [15:0] frames_fwd, frames_drop;
  logic [15:0] exp_fwd = 16'd0, exp_drop = 16'd0;
`endif

  ipv4_header_extractor #(.TAG_WIDTH(16), .ETHERTYPE_IPV4(ETH_IPV4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IPV4_EXTRACT_STATS_EN
    ,
    .frames_fwd  (frames_fwd),
    .frames_drop (frames_drop)
`endif
  );

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          emits_exp = 0, emits_seen = 0;
  int          cur_idx = -1, drop_idx = -1;
  int          hold_cnt = 0, hold_cfg = 0, bubble_pct = 0;
  bit          cur_good = 0, pend = 0, rdy_exp = 0, last_acc = 0, busy_rand = 0;
  logic [31:0] cur_src, cur_dst, e_src, e_dst;
  logic [15:0] m_tag = 16'd0;

  task automatic check_eq(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // One clock: check at negedge, advance the frame model at posedge, drive at +1
  task automatic cycle();
    bit acc, en_exp;
    @(negedge clk);
    acc    = bus.s_tvalid && bus.s_tready;
    en_exp = pend && !bus.busy;
    check_eq("s_tready", bus.s_tready, rdy_exp && !pend);
    check_eq("enable", bus.enable, en_exp);
    if (bus.enable) emits_seen++;
    if (en_exp) begin
      check_eq("src_ip", bus.src_ip, e_src);
      check_eq("dest_ip", bus.dest_ip, e_dst);
      check_eq("tag", bus.tag, m_tag);
    end
`ifdef IPV4_EXTRACT_STATS_EN
    check_eq("frames_fwd", frames_fwd, exp_fwd);
    check_eq("frames_drop", frames_drop, exp_drop);
`endif
    @(posedge clk);
    last_acc = acc;
    if (en_exp) begin
      pend  = 0;
      m_tag = m_tag + 16'd1;
`ifdef IPV4_EXTRACT_STATS_EN
      if (exp_fwd != 16'hFFFF) exp_fwd = exp_fwd + 16'd1;
`endif
    end
    if (acc && cur_idx == 8 && cur_good) begin
      pend  = 1;
      e_src = cur_src;
      e_dst = cur_dst;
      emits_exp++;
      if (hold_cfg > 0) hold_cnt = hold_cfg;
    end
`ifdef IPV4_EXTRACT_STATS_EN
    if (acc && drop_idx >= 0 && cur_idx == drop_idx && exp_drop != 16'hFFFF)
      exp_drop = exp_drop + 16'd1;
`endif
    rdy_exp = rst_n;
    #1;
    if (hold_cnt > 0) begin
      bus.busy = 1'b1;
      hold_cnt--;
    end else begin
      bus.busy = busy_rand && ($urandom_range(0, 99) < 35);
    end
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL cycle_budget: got %0d cycles expected below 90000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    cur_idx      = -1;
    pend         = 0;
    rdy_exp      = 0;
    hold_cnt     = 0;
    m_tag        = 16'd0;
`ifdef IPV4_EXTRACT_STATS_EN
    exp_fwd      = 16'd0;
    exp_drop     = 16'd0;
`endif
    repeat (2) cycle();
    #2;
    check_eq("rst_src_ip", bus.src_ip, 32'd0);
    check_eq("rst_dest_ip", bus.dest_ip, 32'd0);
    check_eq("rst_tag", bus.tag, 32'd0);
    check_eq("rst_s_tready", bus.s_tready, 1'b0);
    rst_n = 1'b1;
  endtask

  // Frame built as a byte array in wire order, then sent 4 bytes per beat
  task automatic send_frame(int len, logic [15:0] etype, logic [7:0] vb,
                            logic [31:0] src, logic [31:0] dst, int abort_at = -1);
    logic [7:0] fb [80];
    int         tries, nb;
    bit         hdr_ok;
    for (int b = 0; b < 80; b++) fb[b] = 8'($urandom);
    fb[12] = etype[15:8];
    fb[13] = etype[7:0];
    fb[14] = vb;
    for (int k = 0; k < 4; k++) begin
      fb[26+k] = src[31-8*k -: 8];
      fb[30+k] = dst[31-8*k -: 8];
    end
    hdr_ok   = (etype == ETH_IPV4) && (vb[7:4] == 4'd4);
    cur_good = (len >= 9) && hdr_ok;
    if (len <= 3)       drop_idx = len - 1;
    else if (!hdr_ok)   drop_idx = 3;
    else if (len < 9)   drop_idx = len - 1;
    else                drop_idx = -1;
    cur_src = src;
    cur_dst = dst;
    for (int i = 0; i < len; i++) begin
      nb = ($urandom_range(0, 99) < bubble_pct) ? $urandom_range(1, 2) : 0;
      for (int j = 0; j < nb; j++) begin
        bus.s_tvalid = 1'b0;
        cur_idx      = -1;
        cycle();
      end
      bus.s_tdata  = {fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]};
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = (i == len - 1);
      cur_idx      = i;
      if (i == abort_at) return;
      tries = 0;
      do begin
        cycle();
        tries++;
      end while (!last_acc && tries < 100);
      if (!last_acc) begin
        check_eq("beat_accept", last_acc, 1'b1);
        bus.s_tvalid = 1'b0;
        cur_idx      = -1;
        return;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    cur_idx      = -1;
  endtask

  initial begin
    int          r, len;
    logic [15:0] et;
    logic [7:0]  vb;

    bus.s_tdata  = 32'd0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.busy     = 1'b0;
    apply_reset();

    send_frame(16, ETH_IPV4, 8'h45, 32'hC0A8010A, 32'h0A000001);
    send_frame(16, ETH_IPV4, 8'h45, 32'hC0A8010A, 32'h0A000001);
    send_frame(15, 16'h0806, 8'h45, 32'h11111111, 32'h22222222);
    send_frame(16, ETH_IPV4, 8'h45, 32'h01020304, 32'h05060708);
    send_frame(6,  ETH_IPV4, 8'h45, 32'h33333333, 32'h44444444);
    send_frame(9,  ETH_IPV4, 8'h45, 32'hAABBCCDD, 32'h99887766);
    send_frame(16, ETH_IPV4, 8'h65, 32'h55555555, 32'h66666666);

    hold_cfg = 5;
    send_frame(12, ETH_IPV4, 8'h45, 32'hDEADBEEF, 32'hCAFEF00D);
    hold_cfg = 0;
    repeat (3) cycle();

    force dut.tag_cnt_q = 16'hFFFF;
    m_tag = 16'hFFFF;
    cycle();
    release dut.tag_cnt_q;
    send_frame(10, ETH_IPV4, 8'h45, 32'h0A0B0C0D, 32'h01010101);
    send_frame(10, ETH_IPV4, 8'h45, 32'h0E0F1011, 32'h02020202);

    send_frame(16, ETH_IPV4, 8'h45, 32'h77777777, 32'h88888888, 7);
    apply_reset();
    send_frame(16, ETH_IPV4, 8'h45, 32'hC0A8010A, 32'h0A000001);

    busy_rand  = 1;
    bubble_pct = 25;
    for (int f = 0; f < 150; f++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(9, 20);
      et  = ETH_IPV4;
      vb  = 8'h45;
      if (r < 12) begin
        et = 16'($urandom);
        if (et == ETH_IPV4) et = 16'h86DD;
      end else if (r < 22) begin
        vb = {4'($urandom_range(5, 15)), 4'h5};
      end else if (r < 35) begin
        len = $urandom_range(1, 8);
      end
      send_frame(len, et, vb, $urandom, $urandom);
    end
    busy_rand = 0;
    repeat (20) cycle();

    check_eq("emit_count", emits_seen, emits_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
